// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the alu_res_seq decrement sequencer.
//   state_e : FSM encoding (IDLE / RUN / DONE)
//   FLAG_*  : bit positions of {N,Z,C,V} inside the 4-bit aluflags bus
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_dec_step.sv
// alu_dec_step -- one combinational decrement step.
//   acc_i    : current accumulator value
//   acc_o    : accumulator after one decrement
//   borrow_o : decrement started from zero
//   ovf_o    : decrement started from the most negative value
// Macro ALU_RES_SAT_EN: when defined, decrementing zero holds at zero
// (borrow still reported) and signed underflow is never reported.
module alu_dec_step #(
  parameter int ANCHO = 4
) (
  input  logic [ANCHO-1:0] acc_i,
  output logic [ANCHO-1:0] acc_o,
  output logic             borrow_o,
  output logic             ovf_o
);

  localparam logic [ANCHO-1:0] MOST_NEG = {1'b1, {(ANCHO-1){1'b0}}};

  logic is_zero;
  assign is_zero  = (acc_i == '0);
  assign borrow_o = is_zero;

`ifdef ALU_RES_SAT_EN
  assign acc_o = is_zero ? '0 : acc_i - ANCHO'(1);
  assign ovf_o = 1'b0;
`else
  assign acc_o = acc_i - ANCHO'(1);
  assign ovf_o = (acc_i == MOST_NEG);
`endif

endmodule

// File: rtl/alu_res_seq.sv
// alu_res_seq -- accepts an operand (a or b) and a step count n, applies n
// decrements, then presents the result with sticky {N,Z,C,V} flags.
//   clk, rst_n          : clock, async active-low reset
//   clr                 : synchronous abort to IDLE (clears results)
//   a, b, aluflagin     : operand candidates and select (0 -> a, 1 -> b)
//   n                   : number of decrements
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   aluresult, aluflags : registered result and {N,Z,C,V}
// Macro ALU_RES_SAT_EN selects saturating decrement (see alu_dec_step).
module alu_res_seq
  import alu_pkg::*;
#(
  parameter int ANCHO   = 4,
  parameter int PASOS_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [ANCHO-1:0]   a,
  input  logic [ANCHO-1:0]   b,
  input  logic               aluflagin,
  input  logic [PASOS_W-1:0] n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ANCHO-1:0]   aluresult,
  output logic [3:0]         aluflags
);

  state_e             state_q, state_d;
  logic [ANCHO-1:0]   acc_q, acc_d;
  logic [PASOS_W-1:0] cnt_q, cnt_d;
  logic               c_q, c_d, v_q, v_d;
  logic [ANCHO-1:0]   res_q, res_d;
  logic [3:0]         flags_q, flags_d;

  logic [ANCHO-1:0]   step_acc;
  logic               step_borrow, step_ovf;
  logic [ANCHO-1:0]   operand;

  alu_dec_step #(.ANCHO(ANCHO)) u_step (
    .acc_i    (acc_q),
    .acc_o    (step_acc),
    .borrow_o (step_borrow),
    .ovf_o    (step_ovf)
  );

  assign operand = aluflagin ? b : a;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    v_d     = v_q;
    res_d   = res_q;
    flags_d = flags_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d = operand;
          cnt_d = n;
          c_d   = 1'b0;
          v_d   = 1'b0;
          if (n == '0) begin
            // zero steps: result is the operand itself, flags from it
            state_d         = ST_DONE;
            res_d           = operand;
            flags_d         = '0;
            flags_d[FLAG_N] = operand[ANCHO-1];
            flags_d[FLAG_Z] = (operand == '0);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q - PASOS_W'(1);
        c_d   = c_q | step_borrow;
        v_d   = v_q | step_ovf;
        if (cnt_q == PASOS_W'(1)) begin
          // last step: snapshot result together with updated sticky bits
          state_d         = ST_DONE;
          res_d           = step_acc;
          flags_d[FLAG_N] = step_acc[ANCHO-1];
          flags_d[FLAG_Z] = (step_acc == '0);
          flags_d[FLAG_C] = c_d;
          flags_d[FLAG_V] = v_d;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // abort wins over any handshake
    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      c_d     = 1'b0;
      v_d     = 1'b0;
      res_d   = '0;
      flags_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      v_q     <= v_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign aluresult = res_q;
  assign aluflags  = flags_q;

endmodule

// File: tb/tb_alu_res_seq.sv
// tb_alu_res_seq -- scoreboard bench for alu_res_seq (ANCHO=4, PASOS_W=4).
// Expected results come from a behavioural loop model and are queued at
// accept time, then popped when out_valid is seen.
module tb_alu_res_seq;

  logic       clk, rst_n, clr;
  logic [3:0] a, b, n;
  logic       aluflagin, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] aluresult, aluflags;

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] flags;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_res_seq #(.ANCHO(4), .PASOS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .a(a), .b(b),
    .aluflagin(aluflagin), .n(n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluresult(aluresult), .aluflags(aluflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural reference: {res, flags N Z C V}
  function automatic logic [7:0] model(input logic [3:0] s, input int steps);
    logic [3:0] acc;
    logic c, v;
    acc = s; c = 1'b0; v = 1'b0;
    for (int i = 0; i < steps; i++) begin
      if (acc == 4'd0) c = 1'b1;
`ifdef ALU_RES_SAT_EN
      if (acc != 4'd0) acc = acc - 4'd1;
`else
      if (acc == 4'h8) v = 1'b1;
      acc = acc - 4'd1;
`endif
    end
    return {acc, acc[3], (acc == 4'd0), c, v};
  endfunction

  // called in the phase just after a rising edge, with the DUT idle
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_,
                        input logic sel, input logic [3:0] tn);
    exp_t e, got;
    logic [7:0] m;
    int lat;
    bit seen;
    a = ta; b = tb_; aluflagin = sel; n = tn; in_valid = 1'b1;
    m = model(sel ? tb_ : ta, int'(tn));
    e.res = m[7:4]; e.flags = m[3:0]; e.lat = int'(tn);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; n = $urandom; aluflagin = $urandom;
    sb_q.push_back(e);
    lat = 0; seen = 0;
    while (!seen && lat <= 20) begin
      if (out_valid) seen = 1;
      else begin @(posedge clk); #1; lat++; end
    end
    n_cmp++;
    if (!seen || lat != e.lat) begin
      n_bad++;
      $display("FAIL latency n=%0d: got %0d (seen=%0d) need %0d", tn, lat, seen, e.lat);
    end
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: empty on output");
    end else begin
      got = sb_q.pop_front();
      n_cmp++;
      if (aluresult !== got.res) begin
        n_bad++;
        $display("FAIL result op=%h n=%0d: got %h need %h", sel ? tb_ : ta, tn, aluresult, got.res);
      end
      n_cmp++;
      if (aluflags !== got.flags) begin
        n_bad++;
        $display("FAIL flags op=%h n=%0d: got %b need %b", sel ? tb_ : ta, tn, aluflags, got.flags);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL release: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    end
  endtask

  task automatic check_zero_idle(input string tag);
    n_cmp++;
    if (aluresult !== 4'd0 || aluflags !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: res=%h flags=%b ov=%b ir=%b need 0/0000/0/1",
               tag, aluresult, aluflags, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; n = '0; aluflagin = 1'b0;
    #3;
    check_zero_idle("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    // first op immediately after reset release: accepted on first edge
    run_op(4'd5, 4'd0, 1'b0, 4'd3);
    run_op(4'd0, 4'd1, 1'b1, 4'd2);
    run_op(4'h8, 4'd0, 1'b0, 4'd1);
    run_op(4'd9, 4'd0, 1'b0, 4'd0);
    run_op(4'd0, 4'd0, 1'b0, 4'd15);
  endtask

  task automatic test_hold;
    logic [7:0] m;
    m = model(4'd6, 2);
    a = 4'd6; aluflagin = 1'b0; n = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 4'd1; n = 4'd0;         // keep requesting a different op
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || aluresult !== m[7:4] || aluflags !== m[3:0]) begin
        n_bad++;
        $display("FAIL hold cyc%0d: ov=%b ir=%b res=%h flags=%b need 1/0/%h/%b",
                 i, out_valid, in_ready, aluresult, aluflags, m[7:4], m[3:0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || aluresult !== m[7:4]) begin
      n_bad++;
      $display("FAIL hold_release: ir=%b ov=%b res=%h need 1/0/%h", in_ready, out_valid, aluresult, m[7:4]);
    end
  endtask

  task automatic start_long;
    a = 4'd3; aluflagin = 1'b0; n = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_abort;
    start_long();
    rst_n = 1'b0;
    #1;
    check_zero_idle("reset_mid_run");
    rst_n = 1'b1;
    run_op(4'd3, 4'd0, 1'b0, 4'd1);
    start_long();
    clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check_zero_idle("clr_mid_run");
    run_op(4'd3, 4'd0, 1'b0, 4'd1);
    // clr in DONE beats out_ready
    a = 4'd7; n = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; out_ready = 1'b0;
    check_zero_idle("clr_in_done");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++)
      run_op(4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom_range(0, 9)));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
